// File: rtl/speed_ctrl_fsm.sv
// rtl/speed_ctrl_fsm.sv - keypad speed controller with debounce, auto-repeat and saturating speed
//
// Two active-low keys (Key1 = decrement, Key2 = increment) are synchronised
// and debounced. A press gives one step; holding a key auto-repeats after
// FIRST_DELAY cycles, then every REPEAT_RATE cycles. SPEED saturates inside
// [MIN_SPEED, MAX_SPEED]; ENABLE/UP_DOWN let an external up/down counter
// follow SPEED exactly.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RSTn    in   asynchronous active-low reset
//   Key1    in   decrement key, active-low, asynchronous
//   Key2    in   increment key, active-low, asynchronous
//   ENABLE  out  one-cycle pulse when SPEED changes
//   UP_DOWN out  direction of the step: 1 = decrement, 0 = increment
//   SPEED   out  current speed (registered)
//   AT_MIN  out  SPEED == MIN_SPEED
//   AT_MAX  out  SPEED == MAX_SPEED
module speed_ctrl_fsm #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned MIN_SPEED   = 0,
    parameter int unsigned MAX_SPEED   = 15,
    parameter int unsigned INIT_SPEED  = 0,
    parameter int unsigned DEBOUNCE    = 50000,
    parameter int unsigned FIRST_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE = 5000000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Key1,
    input  logic             Key2,
    output logic             ENABLE,
    output logic             UP_DOWN,
    output logic [WIDTH-1:0] SPEED,
    output logic             AT_MIN,
    output logic             AT_MAX
);

    localparam int unsigned DBW      = $clog2(DEBOUNCE + 1);
    localparam int unsigned HOLD_MAX = (FIRST_DELAY > REPEAT_RATE) ? FIRST_DELAY : REPEAT_RATE;
    localparam int unsigned HCW      = $clog2(HOLD_MAX + 1);

    localparam logic [DBW-1:0]   DB_LAST     = DBW'(DEBOUNCE - 1);
    localparam logic [HCW-1:0]   FIRST_LAST  = HCW'(FIRST_DELAY - 1);
    localparam logic [HCW-1:0]   REPEAT_LAST = HCW'(REPEAT_RATE - 1);
    localparam logic [WIDTH-1:0] SPEED_MIN   = WIDTH'(MIN_SPEED);
    localparam logic [WIDTH-1:0] SPEED_MAX   = WIDTH'(MAX_SPEED);
    localparam logic [WIDTH-1:0] SPEED_INIT  = WIDTH'(INIT_SPEED);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } state_e;

    // Bit 0 carries Key1, bit 1 carries Key2 throughout the input path.
    logic [1:0]       key_s1_q, key_s1_d;
    logic [1:0]       key_s2_q, key_s2_d;
    logic [1:0]       key_db_q, key_db_d;
    logic [DBW-1:0]   db_cnt_q [2];
    logic [DBW-1:0]   db_cnt_d [2];

    state_e           state_q, state_d;
    logic             dir_q, dir_d;          // 1 = decrement
    logic             rep_q, rep_d;          // next return from STEP goes to REPEAT
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] speed_q, speed_d;
    logic             enable_q, enable_d;
    logic             up_down_q, up_down_d;

    logic             req_dec, req_inc, req_same;
    logic [HCW-1:0]   hold_last;

    // Synchroniser and debouncer: the debounced level follows the synchronised
    // level only after DEBOUNCE consecutive cycles of disagreement.
    always_comb begin
        key_s1_d = {Key2, Key1};
        key_s2_d = key_s1_q;
        key_db_d = key_db_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (key_s2_q[i] != key_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    key_db_d[i] = key_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    // Both keys down or both up decode to no request.
    assign req_dec  = ~key_db_q[0] &  key_db_q[1];
    assign req_inc  =  key_db_q[0] & ~key_db_q[1];
    assign req_same = dir_q ? req_dec : req_inc;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        rep_d      = rep_q;
        hold_cnt_d = hold_cnt_q;
        speed_d    = speed_q;
        enable_d   = 1'b0;
        up_down_d  = 1'b0;
        hold_last  = (state_q == ST_HOLD) ? FIRST_LAST : REPEAT_LAST;

        case (state_q)
            ST_IDLE: begin
                if (req_dec || req_inc) begin
                    state_d = ST_STEP;
                    dir_d   = req_dec;
                    rep_d   = 1'b0;
                end
            end
            ST_STEP: begin
                up_down_d = dir_q;
                if (dir_q) begin
                    if (speed_q > SPEED_MIN) begin
                        speed_d  = speed_q - WIDTH'(1);
                        enable_d = 1'b1;
                    end
                end else begin
                    if (speed_q < SPEED_MAX) begin
                        speed_d  = speed_q + WIDTH'(1);
                        enable_d = 1'b1;
                    end
                end
                hold_cnt_d = '0;
                state_d    = rep_q ? ST_REPEAT : ST_HOLD;
            end
            ST_HOLD, ST_REPEAT: begin
                if (!req_same) begin
                    state_d = ST_IDLE;
                end else if (hold_cnt_q == hold_last) begin
                    state_d = ST_STEP;
                    rep_d   = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_s1_q    <= 2'b11;
            key_s2_q    <= 2'b11;
            key_db_q    <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            rep_q       <= 1'b0;
            hold_cnt_q  <= '0;
            speed_q     <= SPEED_INIT;
            enable_q    <= 1'b0;
            up_down_q   <= 1'b0;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            key_db_q    <= key_db_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            dir_q       <= dir_d;
            rep_q       <= rep_d;
            hold_cnt_q  <= hold_cnt_d;
            speed_q     <= speed_d;
            enable_q    <= enable_d;
            up_down_q   <= up_down_d;
        end
    end

    assign ENABLE  = enable_q;
    assign UP_DOWN = up_down_q;
    assign SPEED   = speed_q;
    assign AT_MIN  = (speed_q == SPEED_MIN);
    assign AT_MAX  = (speed_q == SPEED_MAX);

endmodule

// File: tb/tb_speed_ctrl_fsm.sv
// tb/tb_speed_ctrl_fsm.sv - self-checking bench for speed_ctrl_fsm
module tb_speed_ctrl_fsm;

    localparam int WD    = 4;
    localparam int MINS  = 2;
    localparam int MAXS  = 5;
    localparam int INITS = 3;
    localparam int DB    = 4;
    localparam int FD    = 8;
    localparam int RR    = 4;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          Key1, Key2;
    logic          ENABLE, UP_DOWN, AT_MIN, AT_MAX;
    logic [WD-1:0] SPEED;

    int errors = 0;
    int checks = 0;

    speed_ctrl_fsm #(
        .WIDTH(WD), .MIN_SPEED(MINS), .MAX_SPEED(MAXS), .INIT_SPEED(INITS),
        .DEBOUNCE(DB), .FIRST_DELAY(FD), .REPEAT_RATE(RR)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .Key1(Key1), .Key2(Key2),
        .ENABLE(ENABLE), .UP_DOWN(UP_DOWN), .SPEED(SPEED),
        .AT_MIN(AT_MIN), .AT_MAX(AT_MAX)
    );

    always #5 CLK = ~CLK;

    // Reference model: keys delayed two samples, a level is accepted once the
    // last DB delayed samples all disagree with it, and a held request steps at
    // fixed offsets from its start (1, FD+2, FD+2+(RR+1), ...).
    bit [1:0] m_s1, m_s2, m_db;
    bit       hist0[$];
    bit       hist1[$];
    bit       m_active, m_dir, m_en, m_ud;
    int       m_p, m_speed;

    task automatic model_reset();
        m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b11;
        hist0.delete(); hist1.delete();
        m_active = 0; m_dir = 0; m_p = 0;
        m_speed = INITS; m_en = 0; m_ud = 0;
    endtask

    task automatic model_edge();
        bit [1:0] s1o, s2o, dbo;
        bit dec, inc, diff;
        s1o = m_s1; s2o = m_s2; dbo = m_db;
        dec = !dbo[0] && dbo[1];
        inc = dbo[0] && !dbo[1];
        m_en = 0; m_ud = 0;
        if (!m_active) begin
            if (dec || inc) begin
                m_active = 1; m_dir = dec; m_p = 0;
            end
        end else begin
            m_p++;
            if (m_p == 1 || (m_p >= FD + 2 && ((m_p - FD - 2) % (RR + 1)) == 0)) begin
                m_ud = m_dir;
                if (m_dir && m_speed > MINS) begin
                    m_speed--; m_en = 1;
                end else if (!m_dir && m_speed < MAXS) begin
                    m_speed++; m_en = 1;
                end
            end else if (!(m_dir ? dec : inc)) begin
                m_active = 0;
            end
        end
        m_s1 = {Key2, Key1};
        m_s2 = s1o;
        hist0.push_back(s2o[0]);
        if (hist0.size() > DB) void'(hist0.pop_front());
        hist1.push_back(s2o[1]);
        if (hist1.size() > DB) void'(hist1.pop_front());
        if (hist0.size() == DB) begin
            diff = 1;
            foreach (hist0[i]) if (hist0[i] == dbo[0]) diff = 0;
            if (diff) m_db[0] = s2o[0];
        end
        if (hist1.size() == DB) begin
            diff = 1;
            foreach (hist1[i]) if (hist1[i] == dbo[1]) diff = 0;
            if (diff) m_db[1] = s2o[1];
        end
    endtask

    // Drive keys, advance one rising edge, update the model, sample 1 ns later.
    task automatic cyc(input logic k1, input logic k2);
        Key1 = k1; Key2 = k2;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic reset_dut(input logic k1, input logic k2);
        #2; RSTn = 1'b0; Key1 = k1; Key2 = k2; model_reset();
        repeat (2) @(posedge CLK);
        #2; RSTn = 1'b1;
    endtask

    task automatic test_reset();
        reset_dut(1, 1);
        checks++;
        if (SPEED !== 4'(INITS) || ENABLE !== 1'b0 || UP_DOWN !== 1'b0 || AT_MIN !== 1'b0 || AT_MAX !== 1'b0) begin
            errors++;
            $display("FAIL reset_values speed=%0d en=%b ud=%b min=%b max=%b required 3 0 0 0 0", SPEED, ENABLE, UP_DOWN, AT_MIN, AT_MAX);
        end
        for (int i = 0; i < 12; i++) cyc(1, 0);
        checks++;
        if (SPEED !== 4'(INITS + 1)) begin
            errors++;
            $display("FAIL reset_pre_speed speed=%0d required %0d", SPEED, INITS + 1);
        end
        #2; RSTn = 1'b0; #1;
        checks++;
        if (SPEED !== 4'(INITS) || ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_async speed=%0d en=%b required 3 0", SPEED, ENABLE);
        end
        reset_dut(1, 1);
    endtask

    task automatic test_single_press();
        int pulses = 0, at = -1;
        logic ud = 1'bx;
        reset_dut(1, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1);
        cyc(1, 0); cyc(1, 0); cyc(1, 1);
        for (int i = 0; i < 23; i++) begin
            cyc(1, (i < 8) ? 1'b0 : 1'b1);
            checks++;
            if (SPEED !== 4'(m_speed) || ENABLE !== m_en) begin
                errors++;
                $display("FAIL press_model i=%0d speed=%0d/%0d en=%b/%b", i, SPEED, m_speed, ENABLE, m_en);
            end
            if (ENABLE === 1'b1) begin pulses++; at = i; ud = UP_DOWN; end
        end
        checks++;
        if (pulses != 1 || at != DB + 3 || ud !== 1'b0 || SPEED !== 4'(INITS + 1)) begin
            errors++;
            $display("FAIL press_single pulses=%0d at=%0d ud=%b speed=%0d required 1 7 0 4", pulses, at, ud, SPEED);
        end
    endtask

    task automatic test_dec_saturate();
        int pulses = 0, at = -1;
        logic ud = 1'bx;
        reset_dut(1, 1);
        for (int i = 0; i < 55; i++) begin
            cyc((i < 40) ? 1'b0 : 1'b1, 1);
            checks++;
            if (SPEED !== 4'(m_speed) || ENABLE !== m_en || AT_MIN !== (m_speed == MINS) || (m_en && UP_DOWN !== m_ud)) begin
                errors++;
                $display("FAIL dec_model i=%0d speed=%0d/%0d en=%b/%b min=%b", i, SPEED, m_speed, ENABLE, m_en, AT_MIN);
            end
            if (ENABLE === 1'b1) begin pulses++; at = i; ud = UP_DOWN; end
        end
        checks++;
        if (pulses != 1 || at != DB + 3 || ud !== 1'b1 || SPEED !== 4'(MINS) || AT_MIN !== 1'b1) begin
            errors++;
            $display("FAIL dec_saturate pulses=%0d at=%0d ud=%b speed=%0d min=%b required 1 7 1 2 1", pulses, at, ud, SPEED, AT_MIN);
        end
    endtask

    task automatic test_inc_saturate();
        int pulses = 0, first = -1, second = -1, bad = 0;
        logic [WD-1:0] prev;
        reset_dut(1, 1);
        for (int i = 0; i < 40; i++) begin
            prev = SPEED;
            cyc(1, 0);
            checks++;
            if (SPEED !== 4'(m_speed) || ENABLE !== m_en || AT_MAX !== (m_speed == MAXS)) begin
                errors++;
                $display("FAIL inc_model i=%0d speed=%0d/%0d en=%b/%b max=%b", i, SPEED, m_speed, ENABLE, m_en, AT_MAX);
            end
            if (ENABLE === 1'b1) begin
                pulses++;
                if (first < 0) first = i; else second = i;
                if (prev == 4'(MAXS)) bad++;
            end
        end
        cyc(1, 1);
        checks++;
        if (pulses != 2 || first != DB + 3 || second != DB + 3 + FD + 1 || bad != 0 || SPEED !== 4'(MAXS) || AT_MAX !== 1'b1) begin
            errors++;
            $display("FAIL inc_saturate pulses=%0d first=%0d second=%0d bad=%0d speed=%0d required 2 7 16 0 5", pulses, first, second, bad, SPEED);
        end
    endtask

    task automatic test_conflict();
        int pulses = 0, at = -1;
        reset_dut(1, 1);
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0);
            if (ENABLE === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || SPEED !== 4'(INITS)) begin
            errors++;
            $display("FAIL conflict_hold pulses=%0d speed=%0d required 0 3", pulses, SPEED);
        end
        for (int i = 0; i < 23; i++) begin
            cyc(1, (i < 8) ? 1'b0 : 1'b1);
            checks++;
            if (SPEED !== 4'(m_speed) || ENABLE !== m_en) begin
                errors++;
                $display("FAIL conflict_model i=%0d speed=%0d/%0d en=%b/%b", i, SPEED, m_speed, ENABLE, m_en);
            end
            if (ENABLE === 1'b1) begin pulses++; at = i; end
        end
        checks++;
        if (pulses != 1 || at != DB + 3 || SPEED !== 4'(INITS + 1)) begin
            errors++;
            $display("FAIL conflict_release pulses=%0d at=%0d speed=%0d required 1 7 4", pulses, at, SPEED);
        end
    endtask

    task automatic test_reset_mid_hold();
        int at = -1;
        reset_dut(1, 1);
        for (int i = 0; i < 25; i++) cyc(1, 0);
        #2; RSTn = 1'b0; model_reset(); #1;
        checks++;
        if (SPEED !== 4'(INITS) || ENABLE !== 1'b0 || UP_DOWN !== 1'b0) begin
            errors++;
            $display("FAIL midhold_async speed=%0d en=%b ud=%b required 3 0 0", SPEED, ENABLE, UP_DOWN);
        end
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (SPEED !== 4'(INITS) || ENABLE !== 1'b0 || UP_DOWN !== 1'b0) begin
            errors++;
            $display("FAIL midhold_during speed=%0d en=%b ud=%b required 3 0 0", SPEED, ENABLE, UP_DOWN);
        end
        #2; RSTn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0);
            checks++;
            if (SPEED !== 4'(m_speed) || ENABLE !== m_en) begin
                errors++;
                $display("FAIL midhold_model i=%0d speed=%0d/%0d en=%b/%b", i, SPEED, m_speed, ENABLE, m_en);
            end
            if (ENABLE === 1'b1 && at < 0) at = i + 1;
        end
        checks++;
        if (at != DB + 4 || SPEED !== 4'(INITS + 1)) begin
            errors++;
            $display("FAIL midhold_restart edges=%0d speed=%0d required %0d 4", at, SPEED, DB + 4);
        end
    endtask

    task automatic test_random();
        logic k1, k2;
        int len, sel;
        reset_dut(1, 1);
        for (int s = 0; s < 45; s++) begin
            sel = $urandom_range(0, 9);
            k1 = (sel < 4) ? 1'b0 : (sel == 8) ? 1'b0 : 1'b1;
            k2 = (sel >= 4 && sel < 8) ? 1'b0 : (sel == 8) ? 1'b0 : 1'b1;
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                cyc(k1, k2);
                checks++;
                if (SPEED !== 4'(m_speed) || ENABLE !== m_en || AT_MIN !== (m_speed == MINS) ||
                    AT_MAX !== (m_speed == MAXS) || ((m_en || !m_active) && UP_DOWN !== m_ud)) begin
                    errors++;
                    $display("FAIL random_model seg=%0d speed=%0d/%0d en=%b/%b ud=%b/%b", s, SPEED, m_speed, ENABLE, m_en, UP_DOWN, m_ud);
                end
            end
        end
    endtask

    initial begin
        RSTn = 1'b0; Key1 = 1'b1; Key2 = 1'b1;
        model_reset();
        #1;
        test_reset();
        test_single_press();
        test_dec_saturate();
        test_inc_saturate();
        test_conflict();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
